niosqs_onchip_mem_arbiter: RTL and testbench

- Shares one single-port on-chip RAM between two Avalon-MM masters (m0 = Nios data master, m1 = LCD/DMA master).
- Grants one command per cycle using round-robin arbitration.
- Tracks outstanding reads through a latency pipe and routes read data back to the master that issued each read.
- Gates the RAM clock enable during reset_req and drains in-flight reads before going quiet.

---
 rtl/niosqs_onchip_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_niosqs_onchip_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosqs_onchip_mem_arbiter.sv
// Two-master arbiter sharing one single-port on-chip RAM, with read-return routing and reset_req drain.
// Define NIOSQS_MEMARB_FIXED_PRIO_EN to replace round-robin with fixed m0 priority.
module niosqs_onchip_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              idle
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HOLD} state_t;

  state_t            state, state_nxt;
  logic              req0, req1, gnt0, gnt1, gnt_any, gnt_en;
  logic              push_rd, pipe_busy, pipe_busy_nxt;
  logic              vld_p0, vld_p1, own_p0, own_p1;
  logic              rtn_vld, rtn_own;
  logic [DATA_W-1:0] rd_hold0, rd_hold1;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  // reset_n gates grants so both masters stall while reset is held
  assign gnt_en  = reset_n & (state == ST_RUN) & ~reset_req;
  assign gnt_any = gnt0 | gnt1;

`ifdef NIOSQS_MEMARB_FIXED_PRIO_EN
  assign gnt0 = gnt_en & req0;
  assign gnt1 = gnt_en & req1 & ~req0;
`else
  logic last;

  assign gnt0 = gnt_en & req0 & (~req1 | last);
  assign gnt1 = gnt_en & req1 & (~req0 | ~last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  last <= 1'b1;
    else if (gnt0) last <= 1'b0;
    else if (gnt1) last <= 1'b1;
  end
`endif

  always_comb begin
    mem_chipselect = gnt_any;
    mem_address    = gnt1 ? m1_address : m0_address;
    mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
    mem_write      = 1'b0;
    mem_byteenable = '1;
    push_rd        = 1'b0;
    if (gnt0) begin
      mem_write = m0_write;
      push_rd   = ~m0_write;
      if (m0_write) mem_byteenable = m0_byteenable;
    end else if (gnt1) begin
      mem_write = m1_write;
      push_rd   = ~m1_write;
      if (m1_write) mem_byteenable = m1_byteenable;
    end
  end

  // p0: read issued last cycle; p1: read issued two cycles ago
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      own_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      own_p1 <= 1'b0;
    end else begin
      vld_p0 <= push_rd;
      own_p0 <= gnt1;
      vld_p1 <= vld_p0;
      own_p1 <= own_p0;
    end
  end

  assign rtn_vld       = (RD_LAT == 1) ? vld_p0 : vld_p1;
  assign rtn_own       = (RD_LAT == 1) ? own_p0 : own_p1;
  assign pipe_busy     = (RD_LAT == 1) ? vld_p0 : (vld_p0 | vld_p1);
  assign pipe_busy_nxt = (RD_LAT == 1) ? push_rd : (push_rd | vld_p0);

  // return stage: owner sees RAM q directly, the other master keeps its last word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_hold0 <= '0;
      rd_hold1 <= '0;
    end else begin
      if (m0_readdatavalid) rd_hold0 <= mem_readdata;
      if (m1_readdatavalid) rd_hold1 <= mem_readdata;
    end
  end

  assign m0_readdatavalid = rtn_vld & ~rtn_own;
  assign m1_readdatavalid = rtn_vld & rtn_own;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : rd_hold0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : rd_hold1;
  assign m0_waitrequest   = ~gnt0;
  assign m1_waitrequest   = ~gnt1;
  assign mem_clken        = reset_n & (state != ST_HOLD);
  assign idle             = ~gnt_any & ~pipe_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // DRAIN leaves as soon as the pipe will be empty next cycle, so clken drops right after the last return
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (reset_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!pipe_busy_nxt) state_nxt = reset_req ? ST_HOLD : ST_RUN;
      ST_HOLD:  if (!reset_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  a_m0_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
  a_m1_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_niosqs_onchip_mem_arbiter.sv
// Bench for niosqs_onchip_mem_arbiter: two instances (RD_LAT=1 and 2) share master stimulus,
// each with its own RAM model; read returns are checked against a scoreboard queue.
module tb_niosqs_onchip_mem_arbiter;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    int          due;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset_n, reset_req;
  logic [11:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;

  logic        m0_wait [2];
  logic        m1_wait [2];
  logic [31:0] m0_rd [2];
  logic [31:0] m1_rd [2];
  logic        m0_rdv [2];
  logic        m1_rdv [2];
  logic [11:0] mem_addr [2];
  logic        mem_cs [2];
  logic        mem_we [2];
  logic [3:0]  mem_be [2];
  logic [31:0] mem_wd [2];
  logic        mem_clken [2];
  logic [31:0] mem_rdata [2];
  logic        idle [2];

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  int n0, n1;
  rd_t sb0[$];
  rd_t sb1[$];
  logic [31:0] last_rd [2][2];
  rd_t         mon_e;
  logic [1:0]  mon_rdv;
  int          mon_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    niosqs_onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4), .RD_LAT(gi + 1)) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .reset_req        (reset_req),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_byteenable    (m0_byteenable),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_wait[gi]),
      .m0_readdata      (m0_rd[gi]),
      .m0_readdatavalid (m0_rdv[gi]),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_byteenable    (m1_byteenable),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_wait[gi]),
      .m1_readdata      (m1_rd[gi]),
      .m1_readdatavalid (m1_rdv[gi]),
      .mem_address      (mem_addr[gi]),
      .mem_chipselect   (mem_cs[gi]),
      .mem_write        (mem_we[gi]),
      .mem_byteenable   (mem_be[gi]),
      .mem_writedata    (mem_wd[gi]),
      .mem_clken        (mem_clken[gi]),
      .mem_readdata     (mem_rdata[gi]),
      .idle             (idle[gi])
    );
  end

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h005) ? 32'h0 : {4'hA, a, 4'h5, a};
  endfunction

  // RAM models: instance 0 has unregistered q, instance 1 registered q
  logic [31:0] ram [2][4096];
  logic [11:0] ram_aq [2] = '{12'd0, 12'd0};
  logic [31:0] ram_qr [2] = '{32'd0, 32'd0};
  bit          ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int a = 0; a < 4096; a++) begin
        ram[0][a] <= init_word(12'(a));
        ram[1][a] <= init_word(12'(a));
      end
      ram_ready <= 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (mem_clken[i]) begin
        if (mem_cs[i] && mem_we[i])
          for (int b = 0; b < 4; b++)
            if (mem_be[i][b]) ram[i][mem_addr[i]][8*b +: 8] <= mem_wd[i][8*b +: 8];
        if (mem_cs[i]) ram_aq[i] <= mem_addr[i];
        ram_qr[i] <= ram[i][ram_aq[i]];
      end
    end
  end

  assign mem_rdata[0] = ram[0][ram_aq[0]];
  assign mem_rdata[1] = ram_qr[1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic exp_rd(input logic owner, input logic [31:0] d);
    sb0.push_back('{owner: owner, data: d, due: cyc + 1});
    sb1.push_back('{owner: owner, data: d, due: cyc + 2});
  endtask

  // g: -1 no grant, 0 m0 granted, 1 m1 granted
  task automatic chk_grant(input string tag, input int g, input logic [11:0] a, input logic w,
                           input logic [3:0] be, input logic [31:0] wd);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_i%0d_wait0", tag, i), 64'(m0_wait[i]), 64'(g != 0));
      chk($sformatf("%s_i%0d_wait1", tag, i), 64'(m1_wait[i]), 64'(g != 1));
      chk($sformatf("%s_i%0d_cs", tag, i), 64'(mem_cs[i]), 64'(g >= 0));
      chk($sformatf("%s_i%0d_we", tag, i), 64'(mem_we[i]), 64'((g >= 0) ? w : 1'b0));
      if (g >= 0) begin
        chk($sformatf("%s_i%0d_addr", tag, i), 64'(mem_addr[i]), 64'(a));
        chk($sformatf("%s_i%0d_be", tag, i), 64'(mem_be[i]), 64'(w ? be : 4'hF));
        if (w) chk($sformatf("%s_i%0d_wd", tag, i), 64'(mem_wd[i]), 64'(wd));
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_i%0d_wait0", tag, i), 64'(m0_wait[i]), 64'(1));
      chk($sformatf("%s_i%0d_wait1", tag, i), 64'(m1_wait[i]), 64'(1));
      chk($sformatf("%s_i%0d_rdv", tag, i), 64'({m1_rdv[i], m0_rdv[i]}), 64'(0));
      chk($sformatf("%s_i%0d_rd0", tag, i), 64'(m0_rd[i]), 64'(0));
      chk($sformatf("%s_i%0d_rd1", tag, i), 64'(m1_rd[i]), 64'(0));
      chk($sformatf("%s_i%0d_cs", tag, i), 64'(mem_cs[i]), 64'(0));
      chk($sformatf("%s_i%0d_we", tag, i), 64'(mem_we[i]), 64'(0));
      chk($sformatf("%s_i%0d_clken", tag, i), 64'(mem_clken[i]), 64'(0));
      chk($sformatf("%s_i%0d_idle", tag, i), 64'(idle[i]), 64'(1));
    end
  endtask

  task automatic chk_both(input string tag, input int which, input logic exp);
    for (int i = 0; i < 2; i++)
      if (which == 0) chk($sformatf("%s_i%0d_clken", tag, i), 64'(mem_clken[i]), 64'(exp));
      else            chk($sformatf("%s_i%0d_idle", tag, i), 64'(idle[i]), 64'(exp));
  endtask

  // read-return scoreboard
  always @(negedge clk) begin
    if (!reset_n)
      for (int i = 0; i < 2; i++) begin
        last_rd[i][0] = '0;
        last_rd[i][1] = '0;
      end
    for (int i = 0; i < 2; i++) begin
      mon_rdv = {m1_rdv[i], m0_rdv[i]};
      mon_n   = (i == 0) ? sb0.size() : sb1.size();
      if (mon_n == 0) begin
        if (mon_rdv != 2'b00) chk($sformatf("i%0d_rdv_unexpected", i), 64'(mon_rdv), 64'(0));
      end else begin
        mon_e = (i == 0) ? sb0[0] : sb1[0];
        if (mon_rdv != 2'b00 || mon_e.due <= cyc) begin
          if (i == 0) mon_e = sb0.pop_front();
          else        mon_e = sb1.pop_front();
          chk($sformatf("i%0d_rdv_owner", i), 64'(mon_rdv), 64'(mon_e.owner ? 2'b10 : 2'b01));
          chk($sformatf("i%0d_rdata", i), 64'(mon_e.owner ? m1_rd[i] : m0_rd[i]), 64'(mon_e.data));
          chk($sformatf("i%0d_other_hold", i), 64'(mon_e.owner ? m0_rd[i] : m1_rd[i]),
              64'(last_rd[i][!mon_e.owner]));
          chk($sformatf("i%0d_rd_latency", i), 64'(cyc), 64'(mon_e.due));
          last_rd[i][mon_e.owner] = mon_e.data;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; reset_req = 1'b0;
    m0_read = 1'b1; m0_write = 1'b0; m0_address = 12'h010; m0_byteenable = 4'h0; m0_writedata = '0;
    m1_read = 1'b1; m1_write = 1'b0; m1_address = 12'h020; m1_byteenable = 4'h0; m1_writedata = '0;
    tick(); tick();
    sample(); chk_reset("rst");
    tick();
    reset_n = 1'b1;

`ifdef NIOSQS_MEMARB_FIXED_PRIO_EN
    m1_address = 12'h310;
    for (int k = 0; k < 5; k++) begin
      m0_address = 12'h300 + 12'(k);
      sample(); chk_grant($sformatf("fp%0d", k), 0, m0_address, 1'b0, 4'h0, 32'h0);
      exp_rd(1'b0, init_word(m0_address));
      tick();
    end
    m0_read = 1'b0;
    sample(); chk_grant("fp_m1", 1, 12'h310, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b1, init_word(12'h310));
    tick();
    m1_read = 1'b0;
`else
    sample(); chk_grant("rr_c0", 0, 12'h010, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b0, init_word(12'h010));
    tick();
    m0_address = 12'h011;
    sample(); chk_grant("rr_c1", 1, 12'h020, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b1, init_word(12'h020));
    tick();
    m1_read = 1'b0;
    sample(); chk_grant("rr_c2", 0, 12'h011, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b0, init_word(12'h011));
    tick();
    m0_read = 1'b0;
`endif

    // partial write, read-back, then a write right behind the read
    m0_write = 1'b1; m0_address = 12'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'b0011;
    sample(); chk_grant("wr_be", 0, 12'h005, 1'b1, 4'b0011, 32'hDEADBEEF);
    tick();
    m0_write = 1'b0; m1_read = 1'b1; m1_address = 12'h005; m1_byteenable = 4'b0101;
    sample(); chk_grant("rd_after_wr", 1, 12'h005, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b1, 32'h0000BEEF);
    tick();
    m1_read = 1'b0; m1_write = 1'b1; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
    sample(); chk_grant("wr_after_rd", 1, 12'h005, 1'b1, 4'hF, 32'hFFFFFFFF);
    tick();
    m1_write = 1'b0;
    tick(); tick();
    sample(); chk_both("quiet1", 1, 1'b1);
    tick();

`ifndef NIOSQS_MEMARB_FIXED_PRIO_EN
    n0 = 0; n1 = 0;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m0_address = 12'h100 + 12'(n0);
      m1_address = 12'h200 + 12'(n1);
      sample();
      chk_grant($sformatf("alt%0d", k), k % 2, (k % 2 == 1) ? m1_address : m0_address, 1'b0, 4'h0, 32'h0);
      if (!m0_wait[0]) begin exp_rd(1'b0, init_word(m0_address)); n0++; end
      if (!m1_wait[0]) begin exp_rd(1'b1, init_word(m1_address)); n1++; end
      tick();
    end
    chk("alt_m0_grants", 64'(n0), 64'(4));
    chk("alt_m1_grants", 64'(n1), 64'(4));
    m0_read = 1'b0; m1_read = 1'b0;
    tick(); tick(); tick();
    sample(); chk_both("quiet2", 1, 1'b1);
    tick();
`endif

    // reset_req drain
    m1_read = 1'b1; m1_address = 12'h030;
    sample(); chk_grant("drain_g0", 1, 12'h030, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b1, init_word(12'h030));
    tick();
    m1_read = 1'b0; reset_req = 1'b1; m0_read = 1'b1; m0_address = 12'h040;
    sample(); chk_grant("drain_g1", -1, 12'h0, 1'b0, 4'h0, 32'h0); chk_both("drain_g1", 0, 1'b1);
    tick();
    sample(); chk_grant("drain_g2", -1, 12'h0, 1'b0, 4'h0, 32'h0); chk_both("drain_g2", 0, 1'b1);
    tick();
    sample(); chk_grant("hold_g3", -1, 12'h0, 1'b0, 4'h0, 32'h0); chk_both("hold_g3", 0, 1'b0);
    chk_both("hold_g3", 1, 1'b1);
    tick();
    sample(); chk_both("hold_g4", 0, 1'b0);
    tick();
    reset_req = 1'b0;
    tick();
    sample(); chk_both("resume", 0, 1'b1); chk_grant("resume", 0, 12'h040, 1'b0, 4'h0, 32'h0);
    exp_rd(1'b0, init_word(12'h040));
    tick();
    m0_read = 1'b0;
    tick(); tick(); tick();

    // reset with a read in flight: the return must never appear
    m1_read = 1'b1; m1_address = 12'h050;
    sample(); chk_grant("inflight", 1, 12'h050, 1'b0, 4'h0, 32'h0);
    tick();
    reset_n = 1'b0; m1_read = 1'b0;
    sample(); chk_reset("rst_inflight0");
    tick();
    sample(); chk_reset("rst_inflight1");
    tick();
    reset_n = 1'b1;
    tick(); tick();
    sample(); chk_both("post_rst", 1, 1'b1);
    tick();

    chk("sb0_drained", 64'(sb0.size()), 64'(0));
    chk("sb1_drained", 64'(sb1.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
